// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter and auto-refresh engine.
// After initialisation it grants the bus to one owner at a time: refresh,
// then write, then read. It also raises the periodic refresh request that
// the sequencers watch, and muxes the owner's cmd/addr/bank onto the pins.
// Optional read path: define ARBIT_RD_EN to add the read ports, the READ
// state and the read branch of the arbitration.
module sdram_arbit #(
    parameter int         AREF_PERIOD = 780,
    parameter int         T_RFC       = 7,
    parameter logic [3:0] CMD_NOP     = 4'b0111,
    parameter logic [3:0] CMD_AREF    = 4'b0001
) (
    input  logic        s_clk,
    input  logic        s_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        req_wr,
    output logic        en_wr,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
`ifdef ARBIT_RD_EN
    input  logic        req_rd,
    output logic        en_rd,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
`endif
    output logic        req_aref,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    localparam int REF_W = $clog2(AREF_PERIOD);
    localparam int RFC_W = $clog2(T_RFC + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(AREF_PERIOD - 1);
    localparam logic [RFC_W-1:0] RFC_LAST = RFC_W'(T_RFC);

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    state_t            state_q;
    logic [RFC_W-1:0]  cnt_aref_q;
    logic [REF_W-1:0]  cnt_ref_q;
    logic [REF_W-1:0]  cnt_ref_d;
    logic              req_aref_q;
    logic              req_aref_d;
    logic              en_wr_q;
    logic              cke_q;
    logic              ref_tc;
    logic              aref_start;
`ifdef ARBIT_RD_EN
    logic              en_rd_q;
`endif

    // Refresh timer next state: frozen in INIT, free-running with wrap
    // afterwards; the request is sticky until the arbiter starts a refresh.
    always_comb begin
        ref_tc     = (cnt_ref_q == REF_LAST);
        aref_start = (state_q == ST_ARBIT) && req_aref_q;
        cnt_ref_d  = cnt_ref_q;
        if (state_q == ST_INIT) begin
            cnt_ref_d = '0;
        end else if (ref_tc) begin
            cnt_ref_d = '0;
        end else begin
            cnt_ref_d = cnt_ref_q + 1'b1;
        end
        // A new expiry wins over the clear so a period is never lost
        req_aref_d = req_aref_q;
        if (ref_tc) begin
            req_aref_d = 1'b1;
        end else if (aref_start) begin
            req_aref_d = 1'b0;
        end
    end

    // Refresh timer and pending-request registers
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            cnt_ref_q  <= '0;
            req_aref_q <= 1'b0;
        end else begin
            cnt_ref_q  <= cnt_ref_d;
            req_aref_q <= req_aref_d;
        end
    end

    // Clock enable: low while in reset, high from the first cycle after
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            cke_q <= 1'b0;
        end else begin
            cke_q <= 1'b1;
        end
    end

    // Arbitration FSM with registered one-cycle grant pulses
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q    <= ST_INIT;
            cnt_aref_q <= '0;
            en_wr_q    <= 1'b0;
`ifdef ARBIT_RD_EN
            en_rd_q    <= 1'b0;
`endif
        end else begin
            en_wr_q <= 1'b0;
`ifdef ARBIT_RD_EN
            en_rd_q <= 1'b0;
`endif
            case (state_q)
                ST_INIT: begin
                    if (init_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (req_aref_q) begin
                        state_q    <= ST_AREF;
                        cnt_aref_q <= '0;
                    end else if (req_wr) begin
                        state_q <= ST_WRITE;
                        en_wr_q <= 1'b1;
                    end
`ifdef ARBIT_RD_EN
                    else if (req_rd) begin
                        state_q <= ST_READ;
                        en_rd_q <= 1'b1;
                    end
`endif
                end
                ST_AREF: begin
                    if (cnt_aref_q == RFC_LAST) begin
                        state_q    <= ST_ARBIT;
                        cnt_aref_q <= '0;
                    end else begin
                        cnt_aref_q <= cnt_aref_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    // A refresh raised mid-burst waits for the sequencer to finish
                    if (wr_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
`ifdef ARBIT_RD_EN
                ST_READ: begin
                    if (rd_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
`endif
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Pin mux: combinational from the registered state, zero added latency
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd = (cnt_aref_q == '0) ? CMD_AREF : CMD_NOP;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
`ifdef ARBIT_RD_EN
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
`endif
            default: begin
                sdram_cmd = CMD_NOP;
            end
        endcase
    end

    assign en_wr     = en_wr_q;
    assign req_aref  = req_aref_q;
    assign sdram_cke = cke_q;
`ifdef ARBIT_RD_EN
    assign en_rd     = en_rd_q;
`endif

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed and random stimulus for sdram_arbit, checked each
// cycle against a bus-ownership model built from absolute cycle arithmetic.
module tb_sdram_arbit;

    localparam int         AREF_PERIOD = 780;
    localparam int         T_RFC       = 7;
    localparam logic [3:0] NOP         = 4'b0111;
    localparam logic [3:0] AREF        = 4'b0001;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0010;
    logic [11:0] init_addr = 12'h400;
    logic        req_wr = 1'b0;
    logic        en_wr;
    logic        wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [11:0] wr_addr = 12'h003;
    logic [1:0]  wr_bank = 2'd1;
`ifdef ARBIT_RD_EN
    logic        req_rd = 1'b0;
    logic        en_rd;
    logic        rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [11:0] rd_addr = 12'h055;
    logic [1:0]  rd_bank = 2'd2;
`endif
    logic        req_aref;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    always #5 s_clk = ~s_clk;

    sdram_arbit dut (
        .s_clk      (s_clk),
        .s_rst      (s_rst),
        .init_end   (init_end),
        .init_cmd   (init_cmd),
        .init_addr  (init_addr),
        .req_wr     (req_wr),
        .en_wr      (en_wr),
        .wr_end     (wr_end),
        .wr_cmd     (wr_cmd),
        .wr_addr    (wr_addr),
        .wr_bank    (wr_bank),
`ifdef ARBIT_RD_EN
        .req_rd     (req_rd),
        .en_rd      (en_rd),
        .rd_end     (rd_end),
        .rd_cmd     (rd_cmd),
        .rd_addr    (rd_addr),
        .rd_bank    (rd_bank),
`endif
        .req_aref   (req_aref),
        .sdram_cke  (sdram_cke),
        .sdram_cmd  (sdram_cmd),
        .sdram_addr (sdram_addr),
        .sdram_bank (sdram_bank)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: who owns the bus, how many cycles the refresh timer
    // has run since init, whether a refresh is owed, and refresh progress.
    typedef enum int {O_INIT, O_IDLE, O_REF, O_WR, O_RD} owner_t;
    owner_t owner = O_INIT;
    int     age = 0;
    bit     pend = 1'b0;
    int     ref_done = 0;
    bit     m_en_wr = 1'b0;
    bit     m_en_rd = 1'b0;
    bit     m_cke = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // then compare every output 1 time unit later.
    task automatic step();
        bit          expired;
        bit          to_ref;
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        logic [1:0]  e_bank;
        @(posedge s_clk);
        cyc++;
        if (s_rst) begin
            owner = O_INIT; age = 0; pend = 1'b0; ref_done = 0;
            m_en_wr = 1'b0; m_en_rd = 1'b0; m_cke = 1'b0;
        end else begin
            expired = (owner != O_INIT) && ((age % AREF_PERIOD) == AREF_PERIOD - 1);
            to_ref  = (owner == O_IDLE) && pend;
            m_cke = 1'b1; m_en_wr = 1'b0; m_en_rd = 1'b0;
            if (owner != O_INIT) age++;
            case (owner)
                O_INIT: if (init_end) owner = O_IDLE;
                O_IDLE: begin
                    if (pend) begin
                        owner = O_REF; ref_done = 0;
                    end else if (req_wr) begin
                        owner = O_WR; m_en_wr = 1'b1;
                    end
`ifdef ARBIT_RD_EN
                    else if (req_rd) begin
                        owner = O_RD; m_en_rd = 1'b1;
                    end
`endif
                end
                O_REF: begin
                    ref_done++;
                    if (ref_done == T_RFC + 1) owner = O_IDLE;
                end
                O_WR: if (wr_end) owner = O_IDLE;
`ifdef ARBIT_RD_EN
                O_RD: if (rd_end) owner = O_IDLE;
`endif
                default: owner = O_INIT;
            endcase
            if (expired) pend = 1'b1;
            else if (to_ref) pend = 1'b0;
        end
        #1;
        e_cmd = NOP; e_addr = '0; e_bank = '0;
        case (owner)
            O_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
            O_REF:  e_cmd = (ref_done == 0) ? AREF : NOP;
            O_WR:   begin e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank; end
`ifdef ARBIT_RD_EN
            O_RD:   begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank; end
`endif
            default: e_cmd = NOP;
        endcase
        chk("sdram_cmd", 32'(sdram_cmd), 32'(e_cmd));
        chk("sdram_addr", 32'(sdram_addr), 32'(e_addr));
        chk("sdram_bank", 32'(sdram_bank), 32'(e_bank));
        chk("sdram_cke", 32'(sdram_cke), 32'(m_cke));
        chk("en_wr", 32'(en_wr), 32'(m_en_wr));
        chk("req_aref", 32'(req_aref), 32'(pend));
`ifdef ARBIT_RD_EN
        chk("en_rd", 32'(en_rd), 32'(m_en_rd));
`endif
    endtask

    initial begin
        int k;
        // Reset: held for a few cycles, init command visible, cke low
        for (int i = 0; i < 4; i++) step();
        chk("reset_cke", 32'(sdram_cke), 32'd0);
        chk("reset_cmd", 32'(sdram_cmd), 32'h2);
        s_rst = 1'b0;
        step();
        chk("cke_after_reset", 32'(sdram_cke), 32'd1);
        while (cyc < 50) step();
        chk("init_cmd_pass", 32'(sdram_cmd), 32'h2);

        // init_end rises: first refresh request 781 cycles later
        init_end = 1'b1;
        k = 0;
        do begin
            step(); k++;
        end while (req_aref !== 1'b1 && k < 2000);
        chk("aref_rise_latency", 32'(k), 32'd781);
        step();
        chk("aref_cmd", 32'(sdram_cmd), 32'(AREF));
        chk("aref_req_clear", 32'(req_aref), 32'd0);
        for (int i = 0; i < T_RFC; i++) step();
        chk("aref_last_nop", 32'(sdram_cmd), 32'(NOP));
        step();

        // Plain write: one-cycle grant, pass-through, release on wr_end
        wr_cmd = 4'b0100; wr_addr = 12'h003; wr_bank = 2'd1; req_wr = 1'b1;
        step();
        chk("wr_grant", 32'(en_wr), 32'd1);
        req_wr = 1'b0;
        step();
        chk("wr_grant_one_cycle", 32'(en_wr), 32'd0);
        chk("wr_cmd_pass", 32'(sdram_cmd), 32'h4);
        step(); step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk("wr_release_nop", 32'(sdram_cmd), 32'(NOP));
        step();

        // Timer expires mid-write: refresh deferred until wr_end
        req_wr = 1'b1;
        step();
        req_wr = 1'b0;
        k = 0;
        while (!pend && k < 2000) begin step(); k++; end
        chk("pend_seen_in_write", 32'(pend), 32'd1);
        step(); step(); step();
        chk("no_preempt", 32'(sdram_cmd), 32'h4);
        wr_end = 1'b1; req_wr = 1'b1;
        step();
        wr_end = 1'b0;
        chk("arbit_before_aref", 32'(sdram_cmd), 32'(NOP));
        step();
        chk("aref_after_write", 32'(sdram_cmd), 32'(AREF));
        for (int i = 0; i < T_RFC + 1; i++) step();
        chk("wr_wait_aref", 32'(en_wr), 32'd0);
        step();
        chk("wr_after_aref", 32'(en_wr), 32'd1);
        req_wr = 1'b0;
        step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;

`ifdef ARBIT_RD_EN
        // Write and read together: write first, then read
        req_wr = 1'b1; req_rd = 1'b1;
        step();
        chk("both_wr_first", 32'(en_wr), 32'd1);
        req_wr = 1'b0;
        step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();
        chk("rd_after_wr", 32'(en_rd), 32'd1);
        chk("rd_cmd_pass", 32'(sdram_cmd), 32'(rd_cmd));
        req_rd = 1'b0;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
`endif

        // Reset in the middle of a refresh
        k = 0;
        while (!(owner == O_REF && ref_done == 3) && k < 2000) begin step(); k++; end
        chk("reached_cnt3", 32'(ref_done), 32'd3);
        s_rst = 1'b1; init_end = 1'b0;
        step();
        chk("rst_mid_cke", 32'(sdram_cke), 32'd0);
        chk("rst_mid_req", 32'(req_aref), 32'd0);
        chk("rst_mid_cmd", 32'(sdram_cmd), 32'(init_cmd));
        s_rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        init_end = 1'b1;

        // Random traffic, ignored end pulses, occasional resets
        for (int i = 0; i < 4000; i++) begin
            req_wr    = ($urandom_range(0, 3) == 0);
            wr_end    = ($urandom_range(0, 11) == 0);
            wr_cmd    = 4'($urandom);
            wr_addr   = 12'($urandom);
            wr_bank   = 2'($urandom);
            init_cmd  = 4'($urandom);
            init_addr = 12'($urandom);
            if (($urandom_range(0, 99) == 0) && ($urandom_range(0, 9) == 0)) begin
                wr_end = 1'b0; req_wr = 1'b0;
                for (int j = 0; j < 200; j++) step();
            end
`ifdef ARBIT_RD_EN
            req_rd  = ($urandom_range(0, 3) == 0);
            rd_end  = ($urandom_range(0, 9) == 0);
            rd_cmd  = 4'($urandom);
            rd_addr = 12'($urandom);
            rd_bank = 2'($urandom);
`endif
            s_rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        s_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
